// File: rtl/flash_xip_pkg.sv
// Shared types and helpers for the flash XIP read cache.
package flash_xip_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPassSetup,
    StPassAccess,
    StFillSetup,
    StFillAccess,
    StResp
  } state_e;

  localparam logic [31:0] FlashStartDefault = 32'h3000_0000;
  localparam logic [31:0] FlashEndDefault   = 32'h3fff_ffff;

  // Fields are right-aligned; callers keep the low bits they need.
  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] index;
    logic [31:0] word;
  } addr_split_t;

  function automatic addr_split_t split_addr(input logic [31:0] addr,
                                             input int unsigned off_w,
                                             input int unsigned idx_w);
    addr_split_t s;
    s.word  = (addr >> 2) & ((32'd1 << off_w) - 32'd1);
    s.index = (addr >> (off_w + 2)) & ((32'd1 << idx_w) - 32'd1);
    s.tag   = addr >> (off_w + idx_w + 2);
    return s;
  endfunction

endpackage

// File: rtl/flash_xip_line_ram.sv
// Line storage for the XIP cache: data, tag and valid arrays.
// Combinational read, one word write port, tag/valid set, single-line
// invalidate and whole-cache flush.
module flash_xip_line_ram
  import flash_xip_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_W      = 24,
  localparam int unsigned IdxW      = $clog2(NUM_LINES),
  localparam int unsigned OffW      = $clog2(LINE_WORDS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IdxW-1:0]  rd_idx_i,
  input  logic [OffW-1:0]  rd_word_i,
  output logic [31:0]      rd_data_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic             rd_valid_o,
  input  logic             wr_en_i,
  input  logic [IdxW-1:0]  wr_idx_i,
  input  logic [OffW-1:0]  wr_word_i,
  input  logic [31:0]      wr_data_i,
  input  logic             set_en_i,
  input  logic [IdxW-1:0]  set_idx_i,
  input  logic [TAG_W-1:0] set_tag_i,
  input  logic             clr_en_i,
  input  logic [IdxW-1:0]  clr_idx_i,
  input  logic             flush_i
);

  logic [31:0]          data_q [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;

  assign rd_data_o  = data_q[{rd_idx_i, rd_word_i}];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

  // Data words are written one at a time as the fill progresses.
  always_ff @(posedge clock) begin
    if (wr_en_i) data_q[{wr_idx_i, wr_word_i}] <= wr_data_i;
  end

  // Tag is committed together with the valid bit at the end of a fill.
  always_ff @(posedge clock) begin
    if (set_en_i) tag_q[set_idx_i] <= set_tag_i;
  end

  // Valid update: flush wins over any per-line set or clear.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else begin
      if (clr_en_i) valid_d[clr_idx_i] = 1'b0;
      if (set_en_i) valid_d[set_idx_i] = 1'b1;
    end
  end

  // Valid bits register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

endmodule

// File: rtl/flash_xip_cache.sv
// Direct-mapped read cache in front of the SPI flash APB slave.
// Flash reads are served from line storage or fetched as whole lines;
// everything else is forwarded downstream unchanged.
module flash_xip_cache
  import flash_xip_pkg::*;
#(
  parameter logic [31:0] FLASH_START = FlashStartDefault,
  parameter logic [31:0] FLASH_END   = FlashEndDefault,
  parameter int unsigned NUM_LINES   = 16,
  parameter int unsigned LINE_WORDS  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] s_paddr,
  input  logic        s_psel,
  input  logic        s_penable,
  input  logic [2:0]  s_pprot,
  input  logic        s_pwrite,
  input  logic [31:0] s_pwdata,
  input  logic [3:0]  s_pstrb,
  output logic        s_pready,
  output logic [31:0] s_prdata,
  output logic        s_pslverr,
  output logic [31:0] m_paddr,
  output logic        m_psel,
  output logic        m_penable,
  output logic [2:0]  m_pprot,
  output logic        m_pwrite,
  output logic [31:0] m_pwdata,
  output logic [3:0]  m_pstrb,
  input  logic        m_pready,
  input  logic [31:0] m_prdata,
  input  logic        m_pslverr,
  input  logic        flush,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned OffW = $clog2(LINE_WORDS);
  localparam int unsigned IdxW = $clog2(NUM_LINES);
  localparam int unsigned TagW = 32 - OffW - IdxW - 2;

  state_e          state_q, state_d;
  logic [OffW-1:0] fill_cnt_q, fill_cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [2:0]      prot_q, prot_d;
  logic [3:0]      strb_q, strb_d;
  logic            write_q, write_d;
  logic            err_q, err_d;
  logic            flush_pend_q, flush_pend_d;
  logic [31:0]     hit_q, hit_d;
  logic [31:0]     miss_q, miss_d;

  addr_split_t     s_split, q_split;
  logic [IdxW-1:0] s_idx, q_idx;
  logic [OffW-1:0] s_word, q_word;
  logic [TagW-1:0] s_tag, q_tag;

  logic [31:0]     rd_data;
  logic [TagW-1:0] rd_tag;
  logic            rd_valid;
  logic            wr_en, set_en, clr_en;

  logic            access, cacheable, tag_match, lookup_hit, last_word;
  logic [31:0]     fill_addr;

  assign s_split = split_addr(s_paddr, OffW, IdxW);
  assign q_split = split_addr(addr_q, OffW, IdxW);
  assign s_idx   = s_split.index[IdxW-1:0];
  assign s_word  = s_split.word[OffW-1:0];
  assign s_tag   = s_split.tag[TagW-1:0];
  assign q_idx   = q_split.index[IdxW-1:0];
  assign q_word  = q_split.word[OffW-1:0];
  assign q_tag   = q_split.tag[TagW-1:0];

  logic unused_split;
  assign unused_split = ^{s_split.tag[31:TagW], s_split.index[31:IdxW], s_split.word[31:OffW],
                          q_split.tag[31:TagW], q_split.index[31:IdxW], q_split.word[31:OffW]};

  assign access     = s_psel & s_penable;
  assign cacheable  = (s_paddr >= FLASH_START) && (s_paddr <= FLASH_END) && !s_pwrite;
  assign tag_match  = rd_valid && (rd_tag == s_tag);
  // A flush in the lookup cycle forces a miss.
  assign lookup_hit = tag_match && !flush;
  assign last_word  = (fill_cnt_q == OffW'(LINE_WORDS - 1));
  assign fill_addr  = {addr_q[31:OffW+2], fill_cnt_q, 2'b00};

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

  flash_xip_line_ram #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS),
    .TAG_W     (TagW)
  ) u_line_ram (
    .clock     (clock),
    .reset     (reset),
    .rd_idx_i  (s_idx),
    .rd_word_i (s_word),
    .rd_data_o (rd_data),
    .rd_tag_o  (rd_tag),
    .rd_valid_o(rd_valid),
    .wr_en_i   (wr_en),
    .wr_idx_i  (q_idx),
    .wr_word_i (fill_cnt_q),
    .wr_data_i (m_prdata),
    .set_en_i  (set_en),
    .set_idx_i (q_idx),
    .set_tag_i (q_tag),
    .clr_en_i  (clr_en),
    .clr_idx_i (s_idx),
    .flush_i   (flush)
  );

  // Next-state, APB outputs and line storage control.
  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    prot_d       = prot_q;
    strb_d       = strb_q;
    write_d      = write_q;
    err_d        = err_q;
    flush_pend_d = flush_pend_q | flush;
    hit_d        = hit_q;
    miss_d       = miss_q;

    s_pready  = 1'b0;
    s_prdata  = '0;
    s_pslverr = 1'b0;
    m_paddr   = '0;
    m_psel    = 1'b0;
    m_penable = 1'b0;
    m_pprot   = '0;
    m_pwrite  = 1'b0;
    m_pwdata  = '0;
    m_pstrb   = '0;

    wr_en  = 1'b0;
    set_en = 1'b0;
    clr_en = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (cacheable && lookup_hit) begin
            s_pready = 1'b1;
            s_prdata = rd_data;
            hit_d    = sat_inc(hit_q);
          end else if (cacheable) begin
            state_d      = StFillSetup;
            fill_cnt_d   = '0;
            addr_d       = s_paddr;
            prot_d       = s_pprot;
            err_d        = 1'b0;
            rdata_d      = '0;
            flush_pend_d = 1'b0;
            miss_d       = sat_inc(miss_q);
            // Old contents are overwritten word by word, so drop the line now.
            clr_en       = 1'b1;
          end else begin
            state_d = StPassSetup;
            addr_d  = s_paddr;
            prot_d  = s_pprot;
            write_d = s_pwrite;
            wdata_d = s_pwdata;
            strb_d  = s_pstrb;
            // Writes into a cached line make it stale.
            clr_en  = s_pwrite && tag_match;
          end
        end
      end
      StPassSetup, StPassAccess: begin
        m_psel    = 1'b1;
        m_penable = (state_q == StPassAccess);
        m_paddr   = addr_q;
        m_pprot   = prot_q;
        m_pwrite  = write_q;
        m_pwdata  = wdata_q;
        m_pstrb   = strb_q;
        if (state_q == StPassSetup) begin
          state_d = StPassAccess;
        end else if (m_pready) begin
          rdata_d = m_prdata;
          err_d   = m_pslverr;
          state_d = StResp;
        end
      end
      StFillSetup, StFillAccess: begin
        m_psel    = 1'b1;
        m_penable = (state_q == StFillAccess);
        m_paddr   = fill_addr;
        m_pprot   = prot_q;
        if (state_q == StFillSetup) begin
          state_d = StFillAccess;
        end else if (m_pready) begin
          if (m_pslverr) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            wr_en = 1'b1;
            if (fill_cnt_q == q_word) rdata_d = m_prdata;
            if (last_word) begin
              state_d = StResp;
              set_en  = !flush_pend_q && !flush;
            end else begin
              fill_cnt_d = fill_cnt_q + 1'b1;
              state_d    = StFillSetup;
            end
          end
        end
      end
      StResp: begin
        s_pready  = 1'b1;
        s_prdata  = rdata_q;
        s_pslverr = err_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, latched request and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      fill_cnt_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      prot_q       <= '0;
      strb_q       <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      prot_q       <= prot_d;
      strb_q       <= strb_d;
      write_q      <= write_d;
      err_q        <= err_d;
      flush_pend_q <= flush_pend_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

endmodule

// File: tb/tb_flash_xip_cache.sv
// Directed bench for flash_xip_cache with a wait-state APB slave model.
module tb_flash_xip_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] s_paddr;
  logic        s_psel, s_penable, s_pwrite;
  logic [2:0]  s_pprot;
  logic [31:0] s_pwdata;
  logic [3:0]  s_pstrb;
  logic        s_pready, s_pslverr;
  logic [31:0] s_prdata;
  logic [31:0] m_paddr, m_pwdata, m_prdata;
  logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [2:0]  m_pprot;
  logic [3:0]  m_pstrb;
  logic        flush;
  logic [31:0] hit_cnt, miss_cnt;

  int unsigned waits    = 0;
  int unsigned wait_cnt = 0;
  logic [31:0] err_addr = 32'hffff_fff0;
  int unsigned psel_cycles = 0;
  logic [31:0] ds_addr[$];
  logic [31:0] ds_wdata[$];
  logic        ds_write[$];
  logic [3:0]  ds_strb[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  flash_xip_cache dut (
    .clock    (clock),
    .reset    (reset),
    .s_paddr  (s_paddr),
    .s_psel   (s_psel),
    .s_penable(s_penable),
    .s_pprot  (s_pprot),
    .s_pwrite (s_pwrite),
    .s_pwdata (s_pwdata),
    .s_pstrb  (s_pstrb),
    .s_pready (s_pready),
    .s_prdata (s_prdata),
    .s_pslverr(s_pslverr),
    .m_paddr  (m_paddr),
    .m_psel   (m_psel),
    .m_penable(m_penable),
    .m_pprot  (m_pprot),
    .m_pwrite (m_pwrite),
    .m_pwdata (m_pwdata),
    .m_pstrb  (m_pstrb),
    .m_pready (m_pready),
    .m_prdata (m_prdata),
    .m_pslverr(m_pslverr),
    .flush    (flush),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5a5a_5a5a;
  endfunction

  // Downstream slave: ready after `waits` access-phase wait cycles.
  assign m_pready  = m_psel && m_penable && (wait_cnt == waits);
  assign m_prdata  = (m_psel && m_penable) ? mem_word(m_paddr) : 32'h0;
  assign m_pslverr = m_pready && (m_paddr == err_addr);

  always @(posedge clock) begin
    if (m_psel && m_penable && !m_pready) wait_cnt <= wait_cnt + 1;
    else                                  wait_cnt <= 0;
    if (m_psel) psel_cycles <= psel_cycles + 1;
    if (m_psel && m_penable && m_pready) begin
      ds_addr.push_back(m_paddr);
      ds_wdata.push_back(m_pwdata);
      ds_write.push_back(m_pwrite);
      ds_strb.push_back(m_pstrb);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int unsigned wcyc);
    wcyc = 0;
    @(posedge clock); #1;
    s_paddr   = addr;
    s_pwrite  = wr;
    s_pwdata  = wdata;
    s_pstrb   = wr ? 4'hf : 4'h0;
    s_pprot   = 3'b010;
    s_psel    = 1'b1;
    s_penable = 1'b0;
    @(posedge clock); #1;
    s_penable = 1'b1;
    #1;
    while (!s_pready && wcyc < 200) begin
      @(posedge clock); #1;
      wcyc++;
    end
    check("xfer_done", 32'(s_pready), 32'd1);
    rdata = s_prdata;
    err   = s_pslverr;
    @(posedge clock); #1;
    s_psel    = 1'b0;
    s_penable = 1'b0;
    s_pwrite  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int unsigned wc;
    int unsigned base, p0;

    reset = 1'b1; flush = 1'b0;
    s_paddr = '0; s_psel = 0; s_penable = 0; s_pprot = '0;
    s_pwrite = 0; s_pwdata = '0; s_pstrb = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_pready", 32'(s_pready), 32'd0);
    check("rst_prdata", s_prdata, 32'h0);
    check("rst_pslverr", 32'(s_pslverr), 32'd0);
    check("rst_m_psel", 32'(m_psel), 32'd0);
    check("rst_m_paddr", m_paddr, 32'h0);
    check("rst_hit", hit_cnt, 32'd0);
    check("rst_miss", miss_cnt, 32'd0);
    reset = 1'b0;

    // Cold read with 3 downstream wait states: 4*(2+3)+1 = 21 wait cycles.
    waits = 3;
    base = ds_addr.size();
    apb_xfer(32'h3000_0008, 1'b0, 32'h0, rd, er, wc);
    check("cold_data", rd, 32'h6a5a_5a52);
    check("cold_err", 32'(er), 32'd0);
    check("cold_wait", wc, 32'd21);
    check("cold_nxfer", 32'(ds_addr.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) check("cold_fill_addr", ds_addr[base+i], 32'h3000_0000 + 32'(4*i));
    check("cold_miss", miss_cnt, 32'd1);
    check("cold_hit", hit_cnt, 32'd0);

    // Hit in the same line: zero wait states, no downstream activity.
    p0 = psel_cycles;
    apb_xfer(32'h3000_000c, 1'b0, 32'h0, rd, er, wc);
    check("hit_data", rd, 32'h6a5a_5a56);
    check("hit_wait", wc, 32'd0);
    check("hit_no_psel", psel_cycles - p0, 32'd0);
    check("hit_cnt1", hit_cnt, 32'd1);

    // Same index, different tag: refill then the original line misses again.
    waits = 0;
    apb_xfer(32'h3000_0100, 1'b0, 32'h0, rd, er, wc);
    check("conf_data", rd, 32'h6a5a_5b5a);
    check("conf_wait", wc, 32'd9);
    check("conf_miss", miss_cnt, 32'd2);
    base = ds_addr.size();
    apb_xfer(32'h3000_0000, 1'b0, 32'h0, rd, er, wc);
    check("conf2_data", rd, 32'h6a5a_5a5a);
    check("conf2_nxfer", 32'(ds_addr.size() - base), 32'd4);
    check("conf2_miss", miss_cnt, 32'd3);

    // Pass-through read with 2 waits: setup + 3 access cycles + 1 response.
    waits = 2;
    base = ds_addr.size();
    apb_xfer(32'h1000_1010, 1'b0, 32'h0, rd, er, wc);
    check("pass_rd_data", rd, 32'h4a5a_4a4a);
    check("pass_rd_wait", wc, 32'd5);
    check("pass_rd_nxfer", 32'(ds_addr.size() - base), 32'd1);
    check("pass_rd_addr", ds_addr[base], 32'h1000_1010);
    check("pass_rd_write", 32'(ds_write[base]), 32'd0);

    waits = 0;
    base = ds_addr.size();
    apb_xfer(32'h1000_1004, 1'b1, 32'h1234_5678, rd, er, wc);
    check("pass_wr_addr", ds_addr[base], 32'h1000_1004);
    check("pass_wr_wdata", ds_wdata[base], 32'h1234_5678);
    check("pass_wr_write", 32'(ds_write[base]), 32'd1);
    check("pass_wr_strb", 32'(ds_strb[base]), 32'hf);
    check("pass_wr_rdata", rd, 32'h4a5a_4a5e);
    check("pass_wr_err", 32'(er), 32'd0);

    err_addr = 32'h1000_2000;
    apb_xfer(32'h1000_2000, 1'b0, 32'h0, rd, er, wc);
    check("pass_err", 32'(er), 32'd1);
    err_addr = 32'hffff_fff0;

    // Cache untouched by pass-through traffic.
    p0 = psel_cycles;
    apb_xfer(32'h3000_0004, 1'b0, 32'h0, rd, er, wc);
    check("keep_data", rd, 32'h6a5a_5a5e);
    check("keep_no_psel", psel_cycles - p0, 32'd0);
    check("keep_hit", hit_cnt, 32'd2);
    check("keep_miss", miss_cnt, 32'd3);

    // Range boundaries.
    base = ds_addr.size();
    apb_xfer(32'h4000_0000, 1'b0, 32'h0, rd, er, wc);
    check("above_end_data", rd, 32'h1a5a_5a5a);
    check("above_end_nxfer", 32'(ds_addr.size() - base), 32'd1);
    check("above_end_miss", miss_cnt, 32'd3);
    base = ds_addr.size();
    apb_xfer(32'h3fff_fffc, 1'b0, 32'h0, rd, er, wc);
    check("end_data", rd, 32'h65a5_a5a6);
    check("end_nxfer", 32'(ds_addr.size() - base), 32'd4);
    check("end_miss", miss_cnt, 32'd4);

    // A write into a cached line invalidates it.
    base = ds_addr.size();
    apb_xfer(32'h3000_0004, 1'b1, 32'hcafe_f00d, rd, er, wc);
    check("inv_wr_nxfer", 32'(ds_addr.size() - base), 32'd1);
    apb_xfer(32'h3000_0000, 1'b0, 32'h0, rd, er, wc);
    check("inv_rd_miss", miss_cnt, 32'd5);

    // Error on the second word aborts the fill; the line stays invalid.
    err_addr = 32'h3000_0204;
    base = ds_addr.size();
    apb_xfer(32'h3000_0208, 1'b0, 32'h0, rd, er, wc);
    check("ferr_err", 32'(er), 32'd1);
    check("ferr_nxfer", 32'(ds_addr.size() - base), 32'd2);
    check("ferr_miss", miss_cnt, 32'd6);
    err_addr = 32'hffff_fff0;
    base = ds_addr.size();
    apb_xfer(32'h3000_0208, 1'b0, 32'h0, rd, er, wc);
    check("ferr2_err", 32'(er), 32'd0);
    check("ferr2_data", rd, 32'h6a5a_5852);
    check("ferr2_nxfer", 32'(ds_addr.size() - base), 32'd4);
    check("ferr2_miss", miss_cnt, 32'd7);

    // Flush during a fill: data still returned, line not kept.
    fork
      apb_xfer(32'h3000_0300, 1'b0, 32'h0, rd, er, wc);
      begin
        repeat (4) @(posedge clock);
        #2 flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
      end
    join
    check("fl_data", rd, 32'h6a5a_595a);
    check("fl_miss", miss_cnt, 32'd8);
    base = ds_addr.size();
    apb_xfer(32'h3000_0304, 1'b0, 32'h0, rd, er, wc);
    check("fl2_data", rd, 32'h6a5a_595e);
    check("fl2_nxfer", 32'(ds_addr.size() - base), 32'd4);
    check("fl2_miss", miss_cnt, 32'd9);

    // Flush while idle drops the line just filled.
    @(posedge clock); #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    apb_xfer(32'h3000_0308, 1'b0, 32'h0, rd, er, wc);
    check("fli_miss", miss_cnt, 32'd10);
    check("fli_hit", hit_cnt, 32'd2);

    // Asynchronous reset in the middle of a fill.
    waits = 3;
    @(posedge clock); #1;
    s_paddr = 32'h3000_0400; s_pwrite = 1'b0; s_psel = 1'b1; s_penable = 1'b0;
    @(posedge clock); #1 s_penable = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("mid_fill_psel", 32'(m_psel), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_psel", 32'(m_psel), 32'd0);
    check("arst_penable", 32'(m_penable), 32'd0);
    check("arst_pready", 32'(s_pready), 32'd0);
    check("arst_hit", hit_cnt, 32'd0);
    check("arst_miss", miss_cnt, 32'd0);
    s_psel = 1'b0; s_penable = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    base = ds_addr.size();
    apb_xfer(32'h3000_0400, 1'b0, 32'h0, rd, er, wc);
    check("post_rst_data", rd, 32'h6a5a_5e5a);
    check("post_rst_nxfer", 32'(ds_addr.size() - base), 32'd4);
    check("post_rst_miss", miss_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
